// File: rtl/decode_stage.sv
// decode_stage: RV64I instruction decode.
// Register-file read indices are driven combinationally from the incoming instruction. The
// decoded control, immediate, PC and rd are registered for execute, so they line up with the
// operands the register file returns one cycle later. Load-use hazards against the held
// instruction insert one bubble.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   instr_valid_in          fetch presents a valid instruction
//   instr_in, pc_in         instruction word and its PC
//   stall_in, flush_in      downstream stall (hold) / squash of decode
//   stall_out               to fetch: hold instr/pc (combinational)
//   rs1_out, rs2_out        register-file read indices (combinational)
//   valid_out .. illegal_out registered decode results for execute
module decode_stage #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned REG_IDX_W = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid_in,
  input  logic [31:0]          instr_in,
  input  logic [XLEN-1:0]      pc_in,
  input  logic                 stall_in,
  input  logic                 flush_in,
  output logic                 stall_out,
  output logic [REG_IDX_W-1:0] rs1_out,
  output logic [REG_IDX_W-1:0] rs2_out,
  output logic                 valid_out,
  output logic [XLEN-1:0]      pc_out,
  output logic [REG_IDX_W-1:0] rd_out,
  output logic                 rd_write_out,
  output logic [XLEN-1:0]      imm_out,
  output logic [3:0]           alu_op_out,
  output logic                 src1_pc_out,
  output logic                 src2_imm_out,
  output logic                 word_out,
  output logic                 mem_read_out,
  output logic                 mem_write_out,
  output logic [2:0]           mem_size_out,
  output logic                 branch_out,
  output logic                 jump_out,
  output logic                 illegal_out
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm32  = 7'b0011011;
  localparam logic [6:0] OpReg32  = 7'b0111011;
  localparam logic [6:0] OpMisc   = 7'b0001111;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSll  = 4'd2;
  localparam logic [3:0] AluSlt  = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluOr   = 4'd8;
  localparam logic [3:0] AluAnd  = 4'd9;
  localparam logic [3:0] AluPass = 4'd10;

  logic [6:0]           w_opcode;
  logic [2:0]           w_funct3;
  logic [6:0]           w_funct7;
  logic [REG_IDX_W-1:0] w_rd_idx;
  logic [XLEN-1:0]      w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_shamt6, w_shamt5;
  logic [3:0]           w_alu_f3;
  logic [XLEN-1:0]      w_imm;
  logic [3:0]           w_alu_op;
  logic                 w_rd_write, w_src1_pc, w_src2_imm, w_word, w_mem_read, w_mem_write;
  logic                 w_branch, w_jump, w_illegal, w_rs1_used, w_rs2_used;
  logic                 w_hazard, w_load;

  logic                 r_valid, r_rd_write, r_src1_pc, r_src2_imm, r_word;
  logic                 r_mem_read, r_mem_write, r_branch, r_jump, r_illegal;
  logic [XLEN-1:0]      r_pc, r_imm;
  logic [REG_IDX_W-1:0] r_rd;
  logic [3:0]           r_alu_op;
  logic [2:0]           r_mem_size;

  assign w_opcode = instr_in[6:0];
  assign w_funct3 = instr_in[14:12];
  assign w_funct7 = instr_in[31:25];
  assign w_rd_idx = {{(REG_IDX_W-5){1'b0}}, instr_in[11:7]};
  assign rs1_out  = {{(REG_IDX_W-5){1'b0}}, instr_in[19:15]};
  assign rs2_out  = {{(REG_IDX_W-5){1'b0}}, instr_in[24:20]};

  assign w_imm_i  = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
  assign w_imm_s  = {{(XLEN-12){instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign w_imm_b  = {{(XLEN-12){instr_in[31]}}, instr_in[7], instr_in[30:25], instr_in[11:8],
                     1'b0};
  assign w_imm_u  = {{(XLEN-32){instr_in[31]}}, instr_in[31:12], 12'b0};
  assign w_imm_j  = {{(XLEN-20){instr_in[31]}}, instr_in[19:12], instr_in[20], instr_in[30:21],
                     1'b0};
  assign w_shamt6 = {{(XLEN-6){1'b0}}, instr_in[25:20]};
  assign w_shamt5 = {{(XLEN-5){1'b0}}, instr_in[24:20]};

  // funct3 -> ALU op shared by the register and immediate arithmetic groups; bit 30 picks SRA.
  always_comb begin
    w_alu_f3 = AluAdd;
    unique case (w_funct3)
      3'b000:  w_alu_f3 = AluAdd;
      3'b001:  w_alu_f3 = AluSll;
      3'b010:  w_alu_f3 = AluSlt;
      3'b011:  w_alu_f3 = AluSltu;
      3'b100:  w_alu_f3 = AluXor;
      3'b101:  w_alu_f3 = instr_in[30] ? AluSra : AluSrl;
      3'b110:  w_alu_f3 = AluOr;
      3'b111:  w_alu_f3 = AluAnd;
      default: w_alu_f3 = AluAdd;
    endcase
  end

  always_comb begin
    w_imm       = '0;
    w_alu_op    = AluAdd;
    w_rd_write  = 1'b0;
    w_src1_pc   = 1'b0;
    w_src2_imm  = 1'b0;
    w_word      = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_branch    = 1'b0;
    w_jump      = 1'b0;
    w_illegal   = 1'b0;
    w_rs1_used  = 1'b1;
    w_rs2_used  = 1'b0;
    case (w_opcode)
      OpLui: begin
        w_imm = w_imm_u; w_alu_op = AluPass; w_src2_imm = 1'b1; w_rd_write = 1'b1;
        w_rs1_used = 1'b0;
      end
      OpAuipc: begin
        w_imm = w_imm_u; w_src1_pc = 1'b1; w_src2_imm = 1'b1; w_rd_write = 1'b1;
        w_rs1_used = 1'b0;
      end
      OpJal: begin
        w_imm = w_imm_j; w_src1_pc = 1'b1; w_src2_imm = 1'b1; w_rd_write = 1'b1;
        w_jump = 1'b1; w_rs1_used = 1'b0;
      end
      OpJalr: begin
        w_imm = w_imm_i; w_src2_imm = 1'b1; w_rd_write = 1'b1; w_jump = 1'b1;
      end
      OpBranch: begin
        w_imm = w_imm_b; w_alu_op = AluSub; w_branch = 1'b1; w_rs2_used = 1'b1;
      end
      OpLoad: begin
        w_imm = w_imm_i; w_src2_imm = 1'b1; w_rd_write = 1'b1; w_mem_read = 1'b1;
      end
      OpStore: begin
        w_imm = w_imm_s; w_src2_imm = 1'b1; w_mem_write = 1'b1; w_rs2_used = 1'b1;
      end
      OpImm, OpImm32: begin
        w_word     = (w_opcode == OpImm32);
        w_alu_op   = w_alu_f3;
        w_src2_imm = 1'b1;
        w_rd_write = 1'b1;
        if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
          w_imm = w_word ? w_shamt5 : w_shamt6;
        end else begin
          w_imm = w_imm_i;
        end
      end
      OpReg, OpReg32: begin
        w_word     = (w_opcode == OpReg32);
        w_alu_op   = (w_funct3 == 3'b000 && instr_in[30]) ? AluSub : w_alu_f3;
        w_rd_write = 1'b1;
        w_rs2_used = 1'b1;
        // Only funct7 0x00, or 0x20 for SUB/SRA, exists in the base integer OP group.
        if (w_opcode == OpReg &&
            !(w_funct7 == 7'h00 ||
              (w_funct7 == 7'h20 && (w_funct3 == 3'b000 || w_funct3 == 3'b101)))) begin
          w_illegal = 1'b1;
        end
      end
      OpMisc: ;  // FENCE: valid no-op
      default: w_illegal = 1'b1;
    endcase
    if (instr_in[1:0] != 2'b11) w_illegal = 1'b1;
    if (w_illegal) begin
      w_rd_write  = 1'b0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_branch    = 1'b0;
      w_jump      = 1'b0;
    end
    if (w_rd_idx == '0) w_rd_write = 1'b0;
  end

  // Load-use: the held load's rd is read by the incoming instruction before it is available.
  assign w_hazard = instr_valid_in & r_valid & r_mem_read & (r_rd != '0) &
                    ((w_rs1_used & (rs1_out == r_rd)) | (w_rs2_used & (rs2_out == r_rd)));
  assign stall_out = stall_in | (w_hazard & ~flush_in);
  assign w_load    = instr_valid_in & ~w_hazard;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rd        <= '0;
      r_rd_write  <= 1'b0;
      r_imm       <= '0;
      r_alu_op    <= '0;
      r_src1_pc   <= 1'b0;
      r_src2_imm  <= 1'b0;
      r_word      <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_size  <= '0;
      r_branch    <= 1'b0;
      r_jump      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (flush_in) begin
      r_valid     <= 1'b0;
      r_rd_write  <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_branch    <= 1'b0;
      r_jump      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (!stall_in) begin
      r_valid     <= w_load;
      r_pc        <= pc_in;
      r_rd        <= w_rd_idx;
      r_imm       <= w_imm;
      r_alu_op    <= w_alu_op;
      r_src1_pc   <= w_src1_pc;
      r_src2_imm  <= w_src2_imm;
      r_word      <= w_word;
      r_mem_size  <= (w_mem_read | w_mem_write | w_branch) ? w_funct3 : 3'b000;
      r_rd_write  <= w_load & w_rd_write;
      r_mem_read  <= w_load & w_mem_read;
      r_mem_write <= w_load & w_mem_write;
      r_branch    <= w_load & w_branch;
      r_jump      <= w_load & w_jump;
      r_illegal   <= w_load & w_illegal;
    end
  end

  assign valid_out     = r_valid;
  assign pc_out        = r_pc;
  assign rd_out        = r_rd;
  assign rd_write_out  = r_rd_write;
  assign imm_out       = r_imm;
  assign alu_op_out    = r_alu_op;
  assign src1_pc_out   = r_src1_pc;
  assign src2_imm_out  = r_src2_imm;
  assign word_out      = r_word;
  assign mem_read_out  = r_mem_read;
  assign mem_write_out = r_mem_write;
  assign mem_size_out  = r_mem_size;
  assign branch_out    = r_branch;
  assign jump_out      = r_jump;
  assign illegal_out   = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid_in;
  logic [31:0] instr_in;
  logic [63:0] pc_in;
  logic        stall_in, flush_in, stall_out;
  logic [8:0]  rs1_out, rs2_out, rd_out;
  logic        valid_out, rd_write_out, src1_pc_out, src2_imm_out, word_out;
  logic [63:0] pc_out, imm_out;
  logic [3:0]  alu_op_out;
  logic        mem_read_out, mem_write_out, branch_out, jump_out, illegal_out;
  logic [2:0]  mem_size_out;

  decode_stage #(.XLEN(64), .REG_IDX_W(9)) dut (
    .clk(clk), .reset(reset), .instr_valid_in(instr_valid_in), .instr_in(instr_in),
    .pc_in(pc_in), .stall_in(stall_in), .flush_in(flush_in), .stall_out(stall_out),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .valid_out(valid_out), .pc_out(pc_out),
    .rd_out(rd_out), .rd_write_out(rd_write_out), .imm_out(imm_out), .alu_op_out(alu_op_out),
    .src1_pc_out(src1_pc_out), .src2_imm_out(src2_imm_out), .word_out(word_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out), .mem_size_out(mem_size_out),
    .branch_out(branch_out), .jump_out(jump_out), .illegal_out(illegal_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [8:0]  rd;
    logic        rd_write;
    logic [63:0] imm;
    logic [3:0]  alu;
    logic        src1_pc, src2_imm, word, mem_read, mem_write;
    logic [2:0]  size;
    logic        branch, jump, illegal;
  } dec_t;

  dec_t        m;  // expected contents of the decode output register
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic dec_t kill(input dec_t d);
    dec_t k = d;
    k.valid = 1'b0; k.rd_write = 1'b0; k.mem_read = 1'b0; k.mem_write = 1'b0;
    k.branch = 1'b0; k.jump = 1'b0; k.illegal = 1'b0;
    return k;
  endfunction

  // Reference decode built from the ISA field definitions.
  function automatic dec_t ref_decode(input logic [31:0] ins, input logic [63:0] pc);
    dec_t       d;
    longint     s;
    int         alu_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [3:0] a;
    d = '0;
    d.valid = 1'b1;
    d.pc = pc;
    d.rd = 9'(ins[11:7]);
    s = longint'($signed(ins));
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    a = 4'(alu_tab[f3]);
    if (f3 == 3'd5 && ins[30]) a = 4'd7;
    case (opc)
      7'h37: begin d.imm = 64'((s >>> 12) <<< 12); d.alu = 4'd10; d.src2_imm = 1; d.rd_write = 1;
      end
      7'h17: begin d.imm = 64'((s >>> 12) <<< 12); d.src1_pc = 1; d.src2_imm = 1; d.rd_write = 1;
      end
      7'h6f: begin
        d.imm = 64'(((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12) |
                    (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1));
        d.src1_pc = 1; d.src2_imm = 1; d.rd_write = 1; d.jump = 1;
      end
      7'h67: begin d.imm = 64'(s >>> 20); d.src2_imm = 1; d.rd_write = 1; d.jump = 1; end
      7'h63: begin
        d.imm = 64'(((s >>> 31) <<< 12) | (longint'(ins[7]) << 11) |
                    (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1));
        d.alu = 4'd1; d.branch = 1; d.size = f3;
      end
      7'h03: begin d.imm = 64'(s >>> 20); d.src2_imm = 1; d.rd_write = 1; d.mem_read = 1;
        d.size = f3;
      end
      7'h23: begin d.imm = 64'(((s >>> 25) <<< 5) | longint'(ins[11:7])); d.src2_imm = 1;
        d.mem_write = 1; d.size = f3;
      end
      7'h13, 7'h1b: begin
        d.word = (opc == 7'h1b); d.alu = a; d.src2_imm = 1; d.rd_write = 1;
        if (f3 == 3'd1 || f3 == 3'd5) d.imm = d.word ? 64'(ins[24:20]) : 64'(ins[25:20]);
        else d.imm = 64'(s >>> 20);
      end
      7'h33, 7'h3b: begin
        d.word = (opc == 7'h3b); d.rd_write = 1;
        d.alu = (f3 == 3'd0 && ins[30]) ? 4'd1 : a;
        if (opc == 7'h33 && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))
          d.illegal = 1;
      end
      7'h0f: ;
      default: d.illegal = 1;
    endcase
    if (ins[1:0] != 2'b11) d.illegal = 1;
    if (d.illegal) begin
      d.rd_write = 0; d.mem_read = 0; d.mem_write = 0; d.branch = 0; d.jump = 0;
    end
    if (d.rd == 9'd0) d.rd_write = 0;
    return d;
  endfunction

  function automatic logic hazard(input logic v, input logic [31:0] ins);
    logic u1, u2;
    u1 = !(ins[6:0] inside {7'h37, 7'h17, 7'h6f});
    u2 = ins[6:0] inside {7'h63, 7'h23, 7'h33, 7'h3b};
    return v && m.valid && m.mem_read && m.rd != 9'd0 &&
           ((u1 && 9'(ins[19:15]) == m.rd) || (u2 && 9'(ins[24:20]) == m.rd));
  endfunction

  task automatic check_regs();
    chk("valid_out", 64'(valid_out), 64'(m.valid));
    chk("rd_write_out", 64'(rd_write_out), 64'(m.rd_write));
    chk("mem_read_out", 64'(mem_read_out), 64'(m.mem_read));
    chk("mem_write_out", 64'(mem_write_out), 64'(m.mem_write));
    chk("branch_out", 64'(branch_out), 64'(m.branch));
    chk("jump_out", 64'(jump_out), 64'(m.jump));
    chk("illegal_out", 64'(illegal_out), 64'(m.illegal));
    if (m.valid && !m.illegal) begin
      chk("pc_out", pc_out, m.pc);
      chk("rd_out", 64'(rd_out), 64'(m.rd));
      chk("imm_out", imm_out, m.imm);
      chk("alu_op_out", 64'(alu_op_out), 64'(m.alu));
      chk("src1_pc_out", 64'(src1_pc_out), 64'(m.src1_pc));
      chk("src2_imm_out", 64'(src2_imm_out), 64'(m.src2_imm));
      chk("word_out", 64'(word_out), 64'(m.word));
      chk("mem_size_out", 64'(mem_size_out), 64'(m.size));
    end
  endtask

  task automatic check_zero();
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_pc", pc_out, 64'd0);
    chk("rst_rd", 64'(rd_out), 64'd0);
    chk("rst_rd_write", 64'(rd_write_out), 64'd0);
    chk("rst_imm", imm_out, 64'd0);
    chk("rst_alu", 64'(alu_op_out), 64'd0);
    chk("rst_flags", 64'({src1_pc_out, src2_imm_out, word_out, mem_read_out, mem_write_out,
                          branch_out, jump_out, illegal_out}), 64'd0);
    chk("rst_size", 64'(mem_size_out), 64'd0);
  endtask

  // One cycle: drive inputs just after an edge, check combinational outputs on the falling
  // edge, advance the model, check registered outputs just after the next rising edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                      input logic st, input logic fl, output logic exp_st);
    logic hz;
    dec_t d;
    instr_valid_in = v; instr_in = ins; pc_in = pc; stall_in = st; flush_in = fl;
    @(negedge clk);
    hz = hazard(v, ins);
    exp_st = st | (hz & ~fl);
    chk("stall_out", 64'(stall_out), 64'(exp_st));
    chk("rs1_out", 64'(rs1_out), 64'(ins[19:15]));
    chk("rs2_out", 64'(rs2_out), 64'(ins[24:20]));
    if (fl) m = kill(m);
    else if (!st) begin
      d = ref_decode(ins, pc);
      m = (hz || !v) ? kill(d) : d;
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opc_tab[13] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
                                 7'h33, 7'h1b, 7'h3b, 7'h0f, 7'h73};
    logic [31:0] w;
    int unsigned k;
    w = $urandom;
    k = $urandom_range(0, 15);
    if (k >= 13) return w;
    w[6:0]   = opc_tab[k];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    if ((k == 8 || k == 10) && $urandom_range(0, 3) != 0)
      w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return w;
  endfunction

  initial begin
    logic        s;
    logic [31:0] cur;
    logic [63:0] cur_pc;
    logic        v;
    m = '0;
    reset = 1'b1; instr_valid_in = 1'b0; instr_in = '0; pc_in = '0;
    stall_in = 1'b0; flush_in = 1'b0;
    #1;
    check_zero();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // addi x1,x0,5
    step(1, 32'h00500093, 64'h1000, 0, 0, s);
    chk("addi_imm", imm_out, 64'd5);
    chk("addi_rd_write", 64'(rd_write_out), 64'd1);
    // lw x2,0(x1) then dependent add x3,x2,x1: one bubble, then add
    step(1, 32'h0000A103, 64'h1004, 0, 0, s);
    step(1, 32'h001101B3, 64'h1008, 0, 0, s);
    chk("lu_stall", 64'(s), 64'd1);
    chk("lu_bubble", 64'(valid_out), 64'd0);
    step(1, 32'h001101B3, 64'h1008, 0, 0, s);
    chk("lu_restall", 64'(s), 64'd0);
    chk("lu_add_rd", 64'(rd_out), 64'd3);
    // lw x2; lw x4,0(x5); add x6,x2,x1: dependency is not immediate
    step(1, 32'h0000A103, 64'h100C, 0, 0, s);
    step(1, 32'h0002A203, 64'h1010, 0, 0, s);
    chk("b2b_no_stall", 64'(s), 64'd0);
    step(1, 32'h00110333, 64'h1014, 0, 0, s);
    chk("b2b_no_stall2", 64'(s), 64'd0);
    // beq x1,x2,-4
    step(1, 32'hFE208EE3, 64'h1018, 0, 0, s);
    chk("beq_imm", imm_out, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_branch", 64'(branch_out), 64'd1);
    // downstream stall while instr changes, then flush while stalled
    for (int i = 0; i < 3; i++) step(1, rand_instr(), 64'h2000, 1, 0, s);
    chk("stall_hold_imm", imm_out, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1, 32'h00500093, 64'h2004, 1, 1, s);
    chk("flush_stalled", 64'(valid_out), 64'd0);
    // illegal word and write to x0
    step(1, 32'hFFFFFFFF, 64'h3000, 0, 0, s);
    chk("illegal_flag", 64'(illegal_out), 64'd1);
    step(1, 32'h00000013, 64'h3004, 0, 0, s);
    step(1, 32'h00000073, 64'h3008, 0, 0, s);  // ecall
    step(1, 32'h0000000F, 64'h300C, 0, 0, s);  // fence
    step(1, 32'h0000A103, 64'h3010, 0, 0, s);

    // asynchronous reset between edges
    stall_in = 1'b1;
    reset = 1'b1;
    #2;
    check_zero();
    chk("rst_stall_out", 64'(stall_out), 64'd1);
    reset = 1'b0;
    m = '0;
    step(1, 32'h001101B3, 64'h4000, 0, 0, s);

    // randomized traffic; fetch holds its instruction while stall_out is expected
    cur = 32'h0; cur_pc = 64'h8000; v = 1'b0; s = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!s) begin
        cur = rand_instr();
        cur_pc = cur_pc + 64'd4;
        v = ($urandom_range(0, 99) < 85);
      end
      step(v, cur, cur_pc, ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 6), s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV64I instruction decode stage. Sits between fetch and the register file / execute stage.
- Drives register-file read indices combinationally from the incoming instruction. The register file returns operand values one cycle later, aligned with this block's registered decode outputs.
- Registers decoded control, immediate, PC and destination index for execute.
- Detects load-use hazards against the instruction it currently holds and inserts bubbles.

Parameters:
- XLEN, 64, datapath/immediate/PC width
- REG_IDX_W, 9, register index width; architectural 5-bit fields are zero-extended to this width

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- instr_valid_in  input  1  fetch presents a valid instruction
- instr_in  input  32  instruction word
- pc_in  input  XLEN  PC of instr_in
- stall_in  input  1  downstream stall; hold all outputs
- flush_in  input  1  squash instruction in decode (branch redirect)
- stall_out  output  1  to fetch; hold instr/pc (combinational)
- rs1_out  output  REG_IDX_W  to register file, combinational from instr_in[19:15]
- rs2_out  output  REG_IDX_W  to register file, combinational from instr_in[24:20]
- valid_out  output  1  registered; decoded instruction valid
- pc_out  output  XLEN  registered PC
- rd_out  output  REG_IDX_W  registered destination index
- rd_write_out  output  1  writes rd; forced 0 when rd==0, illegal, or bubble
- imm_out  output  XLEN  sign-extended immediate
- alu_op_out  output  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_IMM
- src1_pc_out  output  1  operand 1 is PC (AUIPC, JAL)
- src2_imm_out  output  1  operand 2 is imm_out
- word_out  output  1  32-bit op (OP-32/OP-IMM-32), result sign-extended
- mem_read_out  output  1  load
- mem_write_out  output  1  store
- mem_size_out  output  3  funct3 of load/store
- branch_out  output  1  conditional branch; funct3 carried in mem_size_out
- jump_out  output  1  JAL/JALR
- illegal_out  output  1  illegal/unsupported encoding

Behaviour:
- Reset (async, active-high): all registered outputs are 0 immediately. stall_out follows its combinational equation with registered terms at 0.
- Decode is combinational from instr_in. Results register on the rising clk edge, giving 1-cycle latency. rs1_out and rs2_out have zero latency.
- Opcodes decoded: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, OP-IMM-32, OP-32, MISC-MEM (FENCE decodes as NOP: valid, no write).
- Illegal encodings: any other opcode, instr_in[1:0]!=2'b11, or a bad funct7 (OP allows only 0x00/0x20; 0x20 only with funct3 000/101).
- SYSTEM decodes as illegal.
- On illegal: valid_out=1, illegal_out=1, all write and memory flags 0.
- Immediates are sign-extended to XLEN for the I, S, B, U and J formats. U-format is shifted left 12. Shift amount is imm[5:0] for 64-bit ops and imm[4:0] for word ops.
- rs1 is "used" by all opcodes except LUI, AUIPC and JAL. rs2 is "used" by BRANCH, STORE, OP and OP-32.
- hazard = instr_valid_in & valid_out & mem_read_out & (rd_out!=0) & ((rs1 used & rs1_out==rd_out) | (rs2 used & rs2_out==rd_out)).
- stall_out = stall_in | (hazard & ~flush_in).
- Edge priority: reset > flush_in > stall_in > hazard > normal.
  - flush_in: valid_out<=0, and rd_write_out, mem_read_out, mem_write_out, branch_out, jump_out, illegal_out <=0. This applies even with stall_in high.
  - stall_in (no flush): every registered output holds.
  - hazard: a bubble is loaded (same clears as flush). The instruction is re-presented by fetch next cycle and decoded normally, because the registered load is then no longer held.
  - instr_valid_in=0: a bubble is loaded.
- Back-to-back loads with a dependent third instruction: only an immediate dependency stalls. Exactly one bubble per load-use.

Test Plan:
- addi x1,x0,5 (0x00500093) valid -> same cycle rs1_out=0; next cycle valid_out=1, rd_out=1, imm_out=5, alu_op_out=0, src2_imm_out=1, rd_write_out=1.
- lw x2,0(x1) (0x0000A103) then add x3,x2,x1 (0x001101B3) -> add cycle: stall_out=1; next edge valid_out=0 (bubble); add re-presented -> stall_out=0, then valid_out=1, rd_out=3, alu_op_out=0.
- beq x1,x2,-4 (0xFE208EE3) -> imm_out=0xFFFFFFFFFFFFFFFC, branch_out=1, rd_write_out=0, rs2_out=2.
- stall_in high 3 cycles while instr_in changes -> all registered outputs unchanged. flush_in with stall_in -> valid_out=0 next edge.
- 0xFFFFFFFF -> valid_out=1, illegal_out=1, rd_write_out=0. addi x0,x0,0 -> rd_write_out=0.
- reset asserted mid-stream between edges -> valid_out and all registered outputs 0 without a clock edge; normal decode resumes after deassertion.
